// File: rtl/io_handshake_unit.sv
`default_nettype none
// ============================================================================
// Module   : io_handshake_unit
// Purpose  : Stall-and-confirm responder for INSW/OUTSS. Holds the core until
//            a debounced button press/release; optional IO_AUTO_CONFIRM_EN
//            replaces the button with an immediate confirm.
// Revision : 1.0 - initial release
// ============================================================================
module io_handshake_unit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                is_input,
  input  logic                is_output,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                confirm_button,
  input  logic [31:0]         out_data,
  output logic                stall,
  output logic [31:0]         input_data,
  output logic                input_valid,
  output logic [31:0]         display_value,
  output logic                waiting_input,
  output logic                waiting_output
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_IN_PRESS    = 3'd1,
    ST_IN_RELEASE  = 3'd2,
    ST_OUT_PRESS   = 3'd3,
    ST_OUT_RELEASE = 3'd4,
    ST_DONE        = 3'd5
  } state_t;

  state_t r_state;
  logic   w_press;
  logic   w_release;

`ifdef IO_AUTO_CONFIRM_EN
  logic w_unused_button;

  assign w_unused_button = confirm_button;
  assign w_press         = 1'b1;
  assign w_release       = 1'b1;
`else
  logic [1:0]         r_sync;
  logic               r_db_level;
  logic [c_CNT_W-1:0] r_db_cnt;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic               r_press;
  logic               r_release;

  assign w_cnt_inc = r_db_cnt + c_CNT_W'(1);

  // The counter clears whenever the synchronized level agrees with the
  // debounced level, so only uninterrupted runs can flip the level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync     <= 2'b00;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], confirm_button};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (r_sync[1] == r_db_level) begin
        r_db_cnt <= '0;
      end else if (w_cnt_inc == c_CNT_W'(DEBOUNCE_CYCLES)) begin
        r_db_level <= ~r_db_level;
        r_db_cnt   <= '0;
        r_press    <= ~r_db_level;
        r_release  <= r_db_level;
      end else begin
        r_db_cnt <= w_cnt_inc;
      end
    end
  end

  assign w_press   = r_press;
  assign w_release = r_release;
`endif

  assign stall = ((r_state == ST_IDLE) && (is_input || is_output)) ||
                 ((r_state != ST_IDLE) && (r_state != ST_DONE));

  // A dropped request in any waiting state is a pipeline flush: return to
  // IDLE without a write pulse; display_value keeps whatever it latched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      input_data     <= 32'h0;
      input_valid    <= 1'b0;
      display_value  <= 32'h0;
      waiting_input  <= 1'b0;
      waiting_output <= 1'b0;
    end else begin
      input_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (is_input) begin
            r_state       <= ST_IN_PRESS;
            waiting_input <= 1'b1;
          end else if (is_output) begin
            r_state        <= ST_OUT_PRESS;
            waiting_output <= 1'b1;
            display_value  <= out_data;
          end
        end
        ST_IN_PRESS: begin
          if (!is_input) begin
            r_state       <= ST_IDLE;
            waiting_input <= 1'b0;
          end else if (w_press) begin
            r_state    <= ST_IN_RELEASE;
            input_data <= 32'(switches);
          end
        end
        ST_IN_RELEASE: begin
          if (!is_input) begin
            r_state       <= ST_IDLE;
            waiting_input <= 1'b0;
          end else if (w_release) begin
            r_state       <= ST_DONE;
            waiting_input <= 1'b0;
            input_valid   <= 1'b1;
          end
        end
        ST_OUT_PRESS: begin
          if (!is_output) begin
            r_state        <= ST_IDLE;
            waiting_output <= 1'b0;
          end else if (w_press) begin
            r_state <= ST_OUT_RELEASE;
          end
        end
        ST_OUT_RELEASE: begin
          if (!is_output) begin
            r_state        <= ST_IDLE;
            waiting_output <= 1'b0;
          end else if (w_release) begin
            r_state        <= ST_DONE;
            waiting_output <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state        <= ST_IDLE;
          waiting_input  <= 1'b0;
          waiting_output <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_handshake_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_handshake_unit
// Purpose  : Randomized scoreboard bench for io_handshake_unit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_io_handshake_unit;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int SW_WIDTH        = 16;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                is_input = 1'b0;
  logic                is_output = 1'b0;
  logic [SW_WIDTH-1:0] switches = '0;
  logic                confirm_button = 1'b0;
  logic [31:0]         out_data = 32'h0;
  logic                stall;
  logic [31:0]         input_data;
  logic                input_valid;
  logic [31:0]         display_value;
  logic                waiting_input;
  logic                waiting_output;

  io_handshake_unit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SW_WIDTH       (SW_WIDTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .is_input      (is_input),
    .is_output     (is_output),
    .switches      (switches),
    .confirm_button(confirm_button),
    .out_data      (out_data),
    .stall         (stall),
    .input_data    (input_data),
    .input_valid   (input_valid),
    .display_value (display_value),
    .waiting_input (waiting_input),
    .waiting_output(waiting_output)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q_in[$];
  logic [31:0] q_disp[$];
  logic [31:0] exp_disp = 32'h0;
  logic [31:0] mon_prev_disp = 32'h0;

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction

  // Monitor: every write pulse and every display change must match the
  // oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset) begin
      mon_prev_disp = 32'h0;
    end else begin
      if (input_valid) begin
        check("stall_low_with_valid", {31'b0, stall}, 32'h0);
        if (q_in.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_input_valid: got data %h, expected no pulse", input_data);
        end else begin
          check("input_data", input_data, q_in.pop_front());
        end
      end
      if (display_value !== mon_prev_disp) begin
        if (q_disp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_display_change: got %h, expected %h", display_value, mon_prev_disp);
        end else begin
          check("display_value", display_value, q_disp.pop_front());
        end
        mon_prev_disp = display_value;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (stall && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (stall) begin
      errors++;
      $display("FAIL %s: stall still %b after %0d cycles, expected 0", name, stall, n);
    end
  endtask

  task automatic press(input int hold);
    confirm_button = 1'b1;
    step(hold);
    confirm_button = 1'b0;
  endtask

  task automatic new_disp(output logic [31:0] d);
    d = $urandom;
    while (d == exp_disp) d = $urandom;
  endtask

  task automatic do_insw(input logic [SW_WIDTH-1:0] sw, input int glitch);
    switches = sw;
    is_input = 1'b1;
    #1;
    check("insw_stall_same_cycle", {31'b0, stall}, 32'h1);
    q_in.push_back(32'(sw));
    if (glitch > 0) begin
      confirm_button = 1'b1;
      step(glitch);
      confirm_button = 1'b0;
      step(8);
      check("glitch_waiting_input", {31'b0, waiting_input}, 32'h1);
      check("glitch_stall", {31'b0, stall}, 32'h1);
    end
    press($urandom_range(6, 9));
    wait_done("insw_done");
    is_input = 1'b0;
    step(2);
  endtask

  task automatic do_outss(input logic [31:0] d);
    out_data  = d;
    is_output = 1'b1;
    #1;
    check("outss_stall_same_cycle", {31'b0, stall}, 32'h1);
    q_disp.push_back(d);
    exp_disp = d;
    step();
    check("display_next_cycle", display_value, d);
    check("waiting_output", {31'b0, waiting_output}, 32'h1);
    step(10);
    check("outss_stall_held", {31'b0, stall}, 32'h1);
    press($urandom_range(6, 9));
    wait_done("outss_done");
    is_output = 1'b0;
    step(2);
  endtask

  task automatic do_abort(input logic [SW_WIDTH-1:0] sw);
    switches       = sw;
    is_input       = 1'b1;
    confirm_button = 1'b1;
    step(10);
    is_input = 1'b0;
    step();
    check("abort_waiting_input", {31'b0, waiting_input}, 32'h0);
    check("abort_stall", {31'b0, stall}, 32'h0);
    confirm_button = 1'b0;
    step(12);
  endtask

  task automatic count_stall(output int n);
    #1;
    n = 0;
    while (stall && n < 10) begin
      n++;
      step();
    end
  endtask

  initial begin
    logic [31:0] d;
    int          n;

    step(2);
    check("rst_input_data", input_data, 32'h0);
    check("rst_input_valid", {31'b0, input_valid}, 32'h0);
    check("rst_display", display_value, 32'h0);
    check("rst_waiting", {30'b0, waiting_input, waiting_output}, 32'h0);
    is_input = 1'b1;
    #1;
    check("rst_stall_follows_req", {31'b0, stall}, 32'h1);
    is_input = 1'b0;
    #1;
    check("rst_stall_idle", {31'b0, stall}, 32'h0);
    reset = 1'b1;
    step(2);

`ifdef IO_AUTO_CONFIRM_EN
    repeat (4) begin
      switches = SW_WIDTH'($urandom);
      is_input = 1'b1;
      q_in.push_back(32'(switches));
      count_stall(n);
      check("auto_insw_stall_cycles", n, 32'd3);
      new_disp(d);
      is_input  = 1'b0;
      is_output = 1'b1;
      out_data  = d;
      #1;
      check("auto_done_gap", {31'b0, stall}, 32'h0);
      q_disp.push_back(d);
      exp_disp = d;
      step();
      count_stall(n);
      check("auto_outss_stall_cycles", n, 32'd3);
      is_output = 1'b0;
      step(2);
    end
`else
    do_insw(16'hA5C3, 0);
    do_outss(32'h12345678);
    do_insw(16'h3C5A, 3);

    // Button already down when the request arrives.
    confirm_button = 1'b1;
    switches       = 16'h1111;
    step(12);
    is_input = 1'b1;
    step(10);
    check("held_waiting_input", {31'b0, waiting_input}, 32'h1);
    switches       = 16'hBEEF;
    confirm_button = 1'b0;
    step(12);
    check("held_stall", {31'b0, stall}, 32'h1);
    q_in.push_back(32'h0000BEEF);
    press(8);
    wait_done("held_done");
    is_input = 1'b0;
    step(2);

    do_abort(16'h7777);

    // Reset in OUT_RELEASE.
    new_disp(d);
    out_data  = d;
    is_output = 1'b1;
    q_disp.push_back(d);
    step();
    confirm_button = 1'b1;
    step(10);
    reset = 1'b0;
    #1;
    check("midrst_display", display_value, 32'h0);
    check("midrst_waiting_output", {31'b0, waiting_output}, 32'h0);
    check("midrst_input_data", input_data, 32'h0);
    check("midrst_stall_follows_req", {31'b0, stall}, 32'h1);
    is_output = 1'b0;
    #1;
    check("midrst_stall_idle", {31'b0, stall}, 32'h0);
    exp_disp = 32'h0;
    step(2);
    confirm_button = 1'b0;
    step(12);
    reset = 1'b1;
    step(3);

    repeat (16) begin
      case ($urandom_range(0, 3))
        0: do_insw(SW_WIDTH'($urandom), 0);
        1: do_insw(SW_WIDTH'($urandom), $urandom_range(1, 3));
        2: begin
          new_disp(d);
          do_outss(d);
        end
        default: do_abort(SW_WIDTH'($urandom));
      endcase
    end
`endif

    step(5);
    check("pending_input_expect", q_in.size(), 32'h0);
    check("pending_display_expect", q_disp.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
